// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/dffe32.sv
// 32-bit register with load enable and async active-low clear to RST_VAL.
module dffe32 #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads imem over req/ack, holds under stall, and
// drops reads made stale by a redirect.
//
// state   | meaning
// S_START | one idle cycle after reset, no request
// S_WAIT  | request at addr_q outstanding
// S_HOLD  | fetched word parked in buf_q until ID accepts it
// S_KILL  | stale read in flight; resume at tgt_q once it acks
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_t state, state_d;

  logic        addr_en, tgt_en, buf_en;
  logic [31:0] addr_d;
  logic [31:0] addr_q, tgt_q, buf_q;
  logic [31:0] pc4;

  dffe32 #(.RST_VAL(RESET_PC)) u_addr (
    .clk(clk), .clrn(clrn), .en(addr_en), .d(addr_d), .q(addr_q)
  );

  dffe32 u_tgt (
    .clk(clk), .clrn(clrn), .en(tgt_en), .d(redirect_pc), .q(tgt_q)
  );

  dffe32 u_buf (
    .clk(clk), .clrn(clrn), .en(buf_en), .d(imem_rdata), .q(buf_q)
  );

  assign pc4       = addr_q + 32'd4;
  assign imem_addr = addr_q;
  assign if_pc4    = pc4;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_START;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    imem_req = 1'b0;
    if_inst  = NOP_INST;
    if_valid = 1'b0;
    addr_en  = 1'b0;
    addr_d   = pc4;
    tgt_en   = 1'b0;
    buf_en   = 1'b0;
    unique case (state)
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            addr_en = 1'b1;
            addr_d  = redirect_pc;
          end else begin
            tgt_en  = 1'b1;
            state_d = S_KILL;
          end
        end else if (imem_ack) begin
          if (!stall) begin
            if_inst  = imem_rdata;
            if_valid = 1'b1;
            addr_en  = 1'b1;
          end else begin
            buf_en  = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          addr_en = 1'b1;
          addr_d  = redirect_pc;
          state_d = S_WAIT;
        end else if (!stall) begin
          if_inst  = buf_q;
          if_valid = 1'b1;
          addr_en  = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_KILL: begin
        imem_req = 1'b1;
        tgt_en   = redirect;
        if (imem_ack) begin
          // A redirect landing on the stale ack is newer than tgt_q.
          addr_en = 1'b1;
          addr_d  = redirect ? redirect_pc : tgt_q;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_START;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with RESET_PC = 0x100.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc4(if_pc4),
    .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] rp);
    @(posedge clk);
    #1;
    imem_ack    = a;
    imem_rdata  = d;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] pc4, input logic [31:0] inst,
                            input logic valid);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".pc4"},   if_pc4, pc4);
    check({tag, ".inst"},  if_inst, inst);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
  endtask

  initial begin
    // reset values while clrn is low
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #12;
    expect_out("rst", 1'b0, 32'h100, 32'h104, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    expect_out("start", 1'b0, 32'h100, 32'h104, 32'h0, 1'b0);

    // zero-wait memory
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hAA00_0000 + i, 1'b0, 1'b0, 32'h0);
      expect_out("zw", 1'b1, 32'h100 + 4*i, 32'h104 + 4*i, 32'hAA00_0000 + i, 1'b1);
    end

    // two wait states per read, starting at 0x10C
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("ws0", 1'b1, 32'h10C + 4*r, 32'h110 + 4*r, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("ws1", 1'b1, 32'h10C + 4*r, 32'h110 + 4*r, 32'h0, 1'b0);
      drive(1'b1, 32'hBB00_0000 + r, 1'b0, 1'b0, 32'h0);
      expect_out("ws2", 1'b1, 32'h10C + 4*r, 32'h110 + 4*r, 32'hBB00_0000 + r, 1'b1);
    end

    // ack under stall parks the word, released when stall falls
    drive(1'b1, 32'h8C22_0004, 1'b1, 1'b0, 32'h0);
    expect_out("hack", 1'b1, 32'h114, 32'h118, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      expect_out("hold", 1'b0, 32'h114, 32'h118, 32'h0, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("hrel", 1'b0, 32'h114, 32'h118, 32'h8C22_0004, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("hnext", 1'b1, 32'h118, 32'h11C, 32'h0, 1'b0);

    // redirect on an ack: data dropped, go to 0x200
    drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 32'h0000_0200);
    expect_out("rack", 1'b1, 32'h118, 32'h11C, 32'h0, 1'b0);
    // redirect while 0x200 pending -> KILL
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2000);
    expect_out("rpend", 1'b1, 32'h200, 32'h204, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("kill", 1'b1, 32'h200, 32'h204, 32'h0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    expect_out("kack", 1'b1, 32'h200, 32'h204, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("k2000", 1'b1, 32'h2000, 32'h2004, 32'h0, 1'b0);

    // redirect with ack to 0x3000, then two redirects in KILL
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_3000);
    expect_out("r3k", 1'b1, 32'h2000, 32'h2004, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4000);
    expect_out("r4k", 1'b1, 32'h3000, 32'h3004, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_5000);
    expect_out("r5k", 1'b1, 32'h3000, 32'h3004, 32'h0, 1'b0);
    drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
    expect_out("kack2", 1'b1, 32'h3000, 32'h3004, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("k5000", 1'b1, 32'h5000, 32'h5004, 32'h0, 1'b0);

    // redirect coinciding with the stale ack in KILL wins over tgt_q
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_6000);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_7000);
    expect_out("kboth", 1'b1, 32'h5000, 32'h5004, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("k7000", 1'b1, 32'h7000, 32'h7004, 32'h0, 1'b0);

    // reset pulse during WAIT
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    imem_rdata = 32'h7777_7777;
    clrn = 1'b0;
    #1;
    expect_out("rpulse", 1'b0, 32'h100, 32'h104, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    expect_out("rstart", 1'b0, 32'h100, 32'h104, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    expect_out("rfirst", 1'b1, 32'h100, 32'h104, 32'h0000_0013, 1'b1);

    // PC wrap at the top of the address space
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expect_out("wredir", 1'b1, 32'h104, 32'h108, 32'h0, 1'b0);
    drive(1'b1, 32'h0040_0093, 1'b0, 1'b0, 32'h0);
    expect_out("wtop", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0040_0093, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("wzero", 1'b1, 32'h0, 32'h4, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage that produces the `if_pc4` / `if_inst` pair consumed by the IF/ID pipeline register. It owns the PC, issues word reads to instruction memory over a req/ack handshake with arbitrary wait states, and inserts NOP bubbles while memory is busy. It holds a fetched instruction while ID is stalled and accepts PC redirects (branch/jump/exception) from later stages, discarding any in-flight read made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clrn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  ID cannot accept a new instruction this cycle.
- `redirect`  in  1  load `redirect_pc` as the next fetch address; outranks `stall`.
- `redirect_pc`  in  32  redirect target, word aligned.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  read address; stable while `imem_req`=1 and not yet acked.
- `imem_ack`  in  1  read data valid this cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  32  instruction word, sampled only when `imem_ack`=1.
- `if_pc4`  out  32  address of the delivered instruction + 4.
- `if_inst`  out  32  delivered instruction, or NOP (32'h0000_0000) on a bubble.
- `if_valid`  out  1  `if_inst` is a real instruction accepted by ID this cycle.

## Operation
- Registers: `addr_q` (request address), `tgt_q` (pending redirect target), `buf_q` (held instruction), `state`.
- `imem_addr` = `addr_q`. `if_pc4` = `addr_q` + 4, mod 2^32; wrap from 32'hFFFF_FFFC gives 0.
- States:
  - START: `imem_req`=0; next state WAIT.
  - WAIT: `imem_req`=1.
  - HOLD: `imem_req`=0; instruction in `buf_q`.
  - KILL: `imem_req`=1; waits for the stale read to complete.
- START: only entered by reset.
- WAIT, `redirect`=1:
  - With `imem_ack`: drop the data, `addr_q`<=`redirect_pc`, stay in WAIT.
  - Without `imem_ack`: `tgt_q`<=`redirect_pc`, go to KILL.
- WAIT, `imem_ack`=1, `stall`=0: deliver `imem_rdata` (`if_valid`=1), `addr_q`<=`addr_q`+4, stay in WAIT.
- WAIT, `imem_ack`=1, `stall`=1: `buf_q`<=`imem_rdata`, go to HOLD (`if_valid`=0).
- WAIT, `imem_ack`=0: bubble, no state change.
- HOLD, `redirect`=1: discard `buf_q`, `addr_q`<=`redirect_pc`, go to WAIT.
- HOLD, `stall`=0: deliver `buf_q` (`if_valid`=1), `addr_q`<=`addr_q`+4, go to WAIT.
- HOLD, `stall`=1: bubble, stay in HOLD.
- KILL, `redirect`=1: `tgt_q`<=`redirect_pc`, so the newest redirect wins.
- KILL, `imem_ack`=1: drop the data, `addr_q`<=`tgt_q` (or `redirect_pc` if `redirect` is asserted in the same cycle), go to WAIT.
- KILL never delivers an instruction.
- Bubble outputs: `if_inst`=0, `if_valid`=0, `if_pc4`=`addr_q`+4.
- A delivered instruction is never cancelled here; squashing instructions already in the pipeline belongs to ID/EX.

## Timing
- While `clrn`=0:
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_inst`=0, `if_pc4`=`RESET_PC`+4, `if_valid`=0.
  - Registers: `tgt_q`=0, `buf_q`=0, state START.
- First request is raised 1 cycle after `clrn` deasserts.
- A reset asserted mid-request abandons the request; memory must tolerate `imem_req` dropping.
- Delivery is combinational from `imem_ack`: a zero-wait memory acking every cycle gives one instruction per cycle.
- Addresses step by +4 with no gaps after a 1-cycle START.
- Redirect latency: the new address appears on `imem_addr` the cycle after `redirect`. In KILL it appears the cycle after the stale ack.
- HOLD to delivery: same cycle `stall` falls.
- `stall` and `redirect` are sampled every cycle. `stall` has no effect in KILL or START.

## Structure
- Shared package `pipeline_pkg`:
  - `NOP_INST` = 32'h0000_0000.
  - Default reset PC constant.
  - Fetch state enum (START, WAIT, HOLD, KILL), 2-bit encoding.
- One sub-module: `dffe32`, a 32-bit register with enable and async active-low clear. Used for `addr_q`, `tgt_q` and `buf_q`; `addr_q` gets the `RESET_PC` preset variant via parameter.
- Next-address mux and FSM are local to `instruction_fetch`.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, zero-wait memory: `imem_addr` sequence 100, 104, 108; `if_pc4` 104, 108, 10C; `if_valid`=1 each cycle from cycle 2.
- Two wait states per read: `if_valid` pattern 0,0,1 repeating; `imem_addr` stable during waits; bubbles carry `if_inst`=0.
- Ack of 32'h8C22_0004 with `stall`=1 for 3 cycles: HOLD for 3 cycles with `imem_req`=0. When `stall` falls, `if_inst`=32'h8C22_0004 and `if_valid`=1, then the next request goes to +4.
- `redirect` to 32'h0000_2000 while a read to 0x200 is pending: the 0x200 ack data is never delivered (`if_valid`=0). The next `imem_addr`=2000.
- `redirect` to 32'h0000_3000 in the same cycle as an ack: data dropped, next `imem_addr`=3000. Two redirects in KILL (4000 then 5000): the fetch resumes at 5000.
- `clrn` pulsed low during WAIT: outputs return to reset values immediately. Fetch restarts at `RESET_PC` after 1 START cycle. PC at 32'hFFFF_FFFC delivered: `if_pc4`=0 and the next address is 0.
